dmem_port_arbiter: RTL and testbench

//  Shares one single-port data memory (comb read, posedge write) between the pipeline MEM stage (cpu) and a DMA/loader port (dma).

---
 rtl/dmem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Arbitrates a single-port data memory between the cpu MEM stage and a DMA/loader port.
// Optional feature: define DMEM_ARB_RR_EN for a round-robin default policy (fixed cpu priority otherwise).
module dmem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a transfer happens on any cycle where req and gnt are both 1;
    // requesters hold req/we/addr/wdata stable until granted.

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CPU   = 2'd1,
        ST_DMA   = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_starve_cnt;
    logic [SW-1:0]   w_starve_nxt;
    logic [BW-1:0]   r_burst_cnt;
    logic [BW-1:0]   w_burst_nxt;
    logic            w_cpu_win;
    logic            w_dma_win;
    logic [DATA_W-1:0] r_rdata;
    logic            r_cpu_rvalid;
    logic            r_dma_rvalid;

`ifdef DMEM_ARB_RR_EN
    logic            r_last_dma;

    // Last-owner bit resets to dma so the cpu wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_last_dma <= 1'b1;
        else if (w_cpu_win || w_dma_win)
            r_last_dma <= w_dma_win;
    end
`endif

    always_comb begin
        w_cpu_win = 1'b0;
        w_dma_win = 1'b0;
        if (!reset_n) begin
            w_cpu_win = 1'b0;
            w_dma_win = 1'b0;
        end else if (r_state == ST_BURST && dma_req && r_burst_cnt < BW'(MAX_BURST)) begin
            w_dma_win = 1'b1;
        end else if (r_starve_cnt == SW'(STARVE_LIMIT) && dma_req) begin
            w_dma_win = 1'b1;
        end else if (r_burst_cnt == BW'(MAX_BURST) && cpu_req) begin
            w_cpu_win = 1'b1;
        end else begin
`ifdef DMEM_ARB_RR_EN
            if (cpu_req && dma_req) begin
                w_cpu_win = r_last_dma;
                w_dma_win = ~r_last_dma;
            end else begin
                w_cpu_win = cpu_req;
                w_dma_win = dma_req;
            end
`else
            w_cpu_win = cpu_req;
            w_dma_win = dma_req & ~cpu_req;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = ST_IDLE;
        w_burst_nxt  = '0;
        w_starve_nxt = '0;
        if (w_dma_win)
            w_state_nxt = dma_lock ? ST_BURST : ST_DMA;
        else if (w_cpu_win)
            w_state_nxt = ST_CPU;
        // Burst count includes the beat that enters BURST; it saturates at MAX_BURST.
        if (w_state_nxt == ST_BURST)
            w_burst_nxt = (r_burst_cnt == BW'(MAX_BURST)) ? r_burst_cnt : r_burst_cnt + 1'b1;
        if (dma_req && !w_dma_win)
            w_starve_nxt = (r_starve_cnt == SW'(STARVE_LIMIT)) ? r_starve_cnt : r_starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_burst_cnt  <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata      <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_win & ~cpu_we;
            r_dma_rvalid <= w_dma_win & ~dma_we;
            if ((w_cpu_win && !cpu_we) || (w_dma_win && !dma_we))
                r_rdata <= mem_rdata;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_win) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dma_win) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_gnt     = w_cpu_win;
    assign dma_gnt     = w_dma_win;
    assign cpu_stall   = cpu_req & ~w_cpu_win;
    assign cpu_rvalid  = r_cpu_rvalid;
    assign dma_rvalid  = r_dma_rvalid;
    assign rdata       = r_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural data memory behind the port.
module tb_dmem_port_arbiter;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CPU   = 2'd1;
    localparam logic [1:0] S_DMA   = 2'd2;
    localparam logic [1:0] S_BURST = 2'd3;
    localparam logic [31:0] D_BEEF = 32'hDEADBEEF;
    localparam logic [31:0] D_1234 = 32'h0000_1234;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [1:0]  o_dbg_state;
    logic [31:0] mem [0:15];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .o_dbg_state(o_dbg_state)
    );

    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_dma, prev_dma;
        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
        repeat (2) tick();

        // reset state; grants blocked while in reset
        cpu_req = 1; #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_cpu_stall", cpu_stall, 1);
        chk("rst_rdata", rdata, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_state", o_dbg_state, S_IDLE);
        cpu_req = 0; tick();
        reset_n = 1; tick();

        // dma write preloads mem[2]
        dma_req = 1; dma_we = 1; dma_addr = 32'h8; dma_wdata = D_BEEF; #1;
        chk("pre_dma_gnt", dma_gnt, 1);
        chk("pre_mem_we", mem_we, 1);
        chk("pre_mem_addr", mem_addr, 32'h8);
        chk("pre_mem_wdata", mem_wdata, D_BEEF);
        tick();
        dma_req = 0; dma_we = 0; #1;
        chk("pre_wr_no_rvalid", dma_rvalid, 0);
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_wdata", mem_wdata, 0);
        chk("pre_state_dma", o_dbg_state, S_DMA);

        // single cpu read
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8; #1;
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_cpu_stall", cpu_stall, 0);
        chk("rd_mem_addr", mem_addr, 32'h8);
        tick();
        cpu_req = 0; #1;
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", rdata, D_BEEF);
        chk("rd_state_cpu", o_dbg_state, S_CPU);
        tick(); #1;
        chk("rd_rvalid_pulse", cpu_rvalid, 0);
        chk("rd_rdata_hold", rdata, D_BEEF);

        // write then read back-to-back, then a dma read right behind
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = D_1234; #1;
        chk("b2b_wr_gnt", cpu_gnt, 1);
        tick();
        cpu_we = 0; #1;
        chk("b2b_wr_no_rvalid", cpu_rvalid, 0);
        chk("b2b_rd_gnt", cpu_gnt, 1);
        tick();
        cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h8; #1;
        chk("b2b_cpu_rvalid", cpu_rvalid, 1);
        chk("b2b_rdata_1234", rdata, D_1234);
        chk("b2b_dma_gnt", dma_gnt, 1);
        tick();
        dma_req = 0; #1;
        chk("b2b_dma_rvalid", dma_rvalid, 1);
        chk("b2b_cpu_rvalid_off", cpu_rvalid, 0);
        chk("b2b_rdata_beef", rdata, D_BEEF);
        tick();

        reset_n = 0; tick();
        reset_n = 1; tick();

        // contention: both ports read continuously for 10 cycles
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
        dma_req = 1; dma_we = 0; dma_addr = 32'h10;
        prev_dma = 0;
        for (int i = 1; i <= 10; i++) begin
            #1;
`ifdef DMEM_ARB_RR_EN
            exp_dma = (i % 2 == 0);
`else
            exp_dma = (i == 5 || i == 10);
`endif
            chk($sformatf("cont_dma_gnt_%0d", i), dma_gnt, exp_dma);
            chk($sformatf("cont_cpu_gnt_%0d", i), cpu_gnt, !exp_dma);
            chk($sformatf("cont_stall_%0d", i), cpu_stall, exp_dma);
            if (i > 1) begin
                chk($sformatf("cont_dma_rvalid_%0d", i), dma_rvalid, prev_dma);
                chk($sformatf("cont_cpu_rvalid_%0d", i), cpu_rvalid, !prev_dma);
                chk($sformatf("cont_rdata_%0d", i), rdata, prev_dma ? D_1234 : D_BEEF);
            end
            prev_dma = exp_dma;
            tick();
        end
        cpu_req = 0; dma_req = 0; tick();

        // locked burst: 8 dma beats, then forced release to the cpu
        dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 32'h8; #1;
        chk("burst_b1_gnt", dma_gnt, 1);
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        for (int i = 2; i <= 8; i++) begin
            #1;
            chk($sformatf("burst_b%0d_gnt", i), dma_gnt, 1);
            chk($sformatf("burst_b%0d_stall", i), cpu_stall, 1);
            chk($sformatf("burst_b%0d_state", i), o_dbg_state, S_BURST);
            tick();
        end
        #1;
        chk("burst_release_cpu", cpu_gnt, 1);
        chk("burst_release_dma", dma_gnt, 0);
        tick();
        cpu_req = 0; dma_req = 0; dma_lock = 0; #1;
        chk("burst_after_state", o_dbg_state, S_CPU);
        chk("burst_after_rvalid", cpu_rvalid, 1);
        chk("burst_after_rdata", rdata, D_1234);
        tick();

        // reset asserted at beat 3 of a locked burst
        dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 32'h10; #1;
        chk("rb_b1_gnt", dma_gnt, 1);
        tick(); #1;
        chk("rb_b2_gnt", dma_gnt, 1);
        tick(); #1;
        chk("rb_b3_gnt", dma_gnt, 1);
        chk("rb_b3_rvalid", dma_rvalid, 1);
        reset_n = 0; #1;
        chk("rb_rst_gnt", dma_gnt, 0);
        chk("rb_rst_rvalid", dma_rvalid, 0);
        chk("rb_rst_state", o_dbg_state, S_IDLE);
        chk("rb_rst_rdata", rdata, 0);
        tick(); #1;
        chk("rb_next_dma_rvalid", dma_rvalid, 0);
        chk("rb_next_cpu_rvalid", cpu_rvalid, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
        reset_n = 1; #1;
        chk("rb_first_cpu_gnt", cpu_gnt, 1);
        chk("rb_first_dma_gnt", dma_gnt, 0);
        tick();
        cpu_req = 0; dma_req = 0; dma_lock = 0; #1;
        chk("rb_first_rvalid", cpu_rvalid, 1);
        chk("rb_first_rdata", rdata, D_BEEF);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
